alu_cmd_issuer: RTL and testbench
=================================

// Module: alu_cmd_issuer
// PURPOSE
//  Sequential initiator for the combinational N-bit ALU. Accepts operation commands over a
//  valid/ready stream, buffers them in a FIFO and drives ALU operands/selector from registers.
//  Captures the ALU result and flags one cycle later and returns them in order on a
//  valid/ready response stream. Sits between the lab control logic and the ALU instance.
// PARAMETERS
//  N      8  operand/result width; must match the ALU instance
//  DEPTH  4  command FIFO entries; power of two, >=2
// PORTS
//  clk           in   1      single clock; all state changes on rising edge
//  rst           in   1      synchronous, active-high reset
//  cmd_valid     in   1      command present
//  cmd_ready     out  1      FIFO not full (0 while rst)
//  cmd_a         in   N      operand a
//  cmd_b         in   N      operand b / shift amount
//  cmd_op        in   4      opcode; alu_pkg::alu_op_e
//  alu_a         out  N      registered operand to ALU
//  alu_b         out  N      registered operand to ALU
//  alu_sel       out  4      registered selector to ALU
//  alu_result    in   N      ALU result
//  alu_neg       in   1      ALU negative flag
//  alu_zero      in   1      ALU zero flag
//  alu_cout      in   1      ALU carry out
//  alu_ovf       in   1      ALU overflow flag
//  rsp_valid     out  1      response held until accepted
//  rsp_ready     in   1      consumer accepts response
//  rsp_result    out  N      captured result
//  rsp_flags     out  4      {neg,zero,cout,ovf}
//  rsp_err       out  1      opcode was illegal (>4'd9)
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, FSM=IDLE, fwd register 0; in-flight op and queue dropped.
//  Push on cmd_valid&&cmd_ready; simultaneous push+pop allowed, count unchanged; never pops empty.
//  FSM IDLE: FIFO non-empty -> pop head into alu_a/b/sel and err_q, go ISSUE.
//  FSM ISSUE (1 cycle): capture alu_* into rsp_*; rsp_valid<=1; go RESP.
//    Illegal op: ALU output ignored; rsp_result=0, rsp_flags=4'b0100, rsp_err=1.
//  FSM RESP: hold rsp_* stable while !rsp_ready. On handshake: rsp_valid<=0; if FIFO non-empty
//    pop next head same edge -> ISSUE, else -> IDLE.
//  Latency: accept edge E0 -> alu regs loaded E1 -> rsp_valid high after E2. Throughput 1 op/2 clk.
//  Responses strictly in command order; alu_* hold last issued values when idle.
//  Opcodes 0..9: add,sub,not,and,or,xor,srl,sll,sra,sla. No arithmetic done locally.
// CONFIGURATION
//  ALU_OPERAND_FWD_EN defined: extra port cmd_fwd (in,1) stored per entry; when set, alu_a is
//    loaded from last_result (result of most recent legal op, updated in ISSUE) instead of cmd_a.
//  Undefined: no cmd_fwd port, no last_result register; alu_a always cmd_a.
// STRUCTURE
//  alu_pkg: alu_op_e enum (ALU_ADD=4'd0..ALU_SLA=4'd9), ALU_OP_MAX=4'd9, alu_flags_t struct,
//    issuer state enum {IDLE,ISSUE,RESP}, FLAGS_ILLEGAL=4'b0100.
//  Sub-module cmd_fifo #(W,DEPTH): sync FIFO, full/empty, ptr wrap at DEPTH.
// TESTING
//  rst=1 2 clk with cmd_valid=1 -> cmd_ready=0, rsp_valid=0, alu_sel=0; after release cmd_ready=1.
//  add 8'h7F,8'h01 -> rsp_result=8'h80, rsp_valid exactly 2 clk after accept edge.
//  sub 8'h05,8'h05 -> rsp_result=8'h00, rsp_flags[2] (zero)=1, rsp_err=0.
//  rsp_ready=0, stream 6 cmds -> 5 accepted then cmd_ready=0; release -> 5 rsps in order.
//  op 4'hC a=8'hFF -> rsp_result=0, rsp_flags=4'b0100, rsp_err=1.
//  With ALU_OPERAND_FWD_EN: add 3,4 then sll fwd=1 b=1 -> rsp 8'h07 then 8'h0E.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode, flag and FSM types for the ALU command issuer.
// Optional feature macro: ALU_OPERAND_FWD_EN (see alu_cmd_issuer).
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_NOT = 4'd2,
        ALU_AND = 4'd3,
        ALU_OR  = 4'd4,
        ALU_XOR = 4'd5,
        ALU_SRL = 4'd6,
        ALU_SLL = 4'd7,
        ALU_SRA = 4'd8,
        ALU_SLA = 4'd9
    } alu_op_e;

    localparam logic [3:0] ALU_OP_MAX = 4'd9;

    typedef struct packed {
        logic neg;
        logic zero;
        logic cout;
        logic ovf;
    } alu_flags_t;

    // Illegal ops report a zero result, so only the zero flag is set.
    localparam alu_flags_t FLAGS_ILLEGAL = 4'b0100;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } issuerState_e;

    function automatic logic isIllegalOp(logic [3:0] op);
        return op > ALU_OP_MAX;
    endfunction

endpackage

// File: rtl/alu_cmd_issuer_if.sv
// Command, ALU and response signals of the ALU command issuer.
// Optional feature macro: ALU_OPERAND_FWD_EN adds cmd_fwd.
interface alu_cmd_issuer_if #(
    parameter int N = 8
);

    logic         cmd_valid;
    logic         cmd_ready;
    logic [N-1:0] cmd_a;
    logic [N-1:0] cmd_b;
    logic [3:0]   cmd_op;
`ifdef ALU_OPERAND_FWD_EN
    logic         cmd_fwd;
`endif

    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [3:0]   alu_sel;
    logic [N-1:0] alu_result;
    logic         alu_neg;
    logic         alu_zero;
    logic         alu_cout;
    logic         alu_ovf;

    logic         rsp_valid;
    logic         rsp_ready;
    logic [N-1:0] rsp_result;
    logic [3:0]   rsp_flags;
    logic         rsp_err;

    modport master (
        input  cmd_valid, cmd_a, cmd_b, cmd_op,
`ifdef ALU_OPERAND_FWD_EN
        input  cmd_fwd,
`endif
        input  alu_result, alu_neg, alu_zero,
        input  alu_cout, alu_ovf,
        input  rsp_ready,
        output cmd_ready,
        output alu_a, alu_b, alu_sel,
        output rsp_valid, rsp_result,
        output rsp_flags, rsp_err
    );

    modport slave (
        output cmd_valid, cmd_a, cmd_b, cmd_op,
`ifdef ALU_OPERAND_FWD_EN
        output cmd_fwd,
`endif
        output alu_result, alu_neg, alu_zero,
        output alu_cout, alu_ovf,
        output rsp_ready,
        input  cmd_ready,
        input  alu_a, alu_b, alu_sel,
        input  rsp_valid, rsp_result,
        input  rsp_flags, rsp_err
    );

endinterface

// File: rtl/cmd_fifo.sv
// Synchronous FIFO for issuer commands; DEPTH must be a power of two.
// Pointers wrap naturally at DEPTH; head word is always visible.
module cmd_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] pushData,
    input  logic         pop,
    output logic [W-1:0] popData,
    output logic         full,
    output logic         empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wrPtr;
    logic [PW-1:0] rdPtr;
    logic [CW-1:0] count;
    logic          doPush;
    logic          doPop;

    assign doPush  = push && !full;
    assign doPop   = pop && !empty;
    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign popData = mem[rdPtr];

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= pushData;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + PW'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + PW'(1);
            end
            unique case ({doPush, doPop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Queues ALU commands, drives the ALU from registers, returns results in order.
// Optional feature macro: ALU_OPERAND_FWD_EN (operand a from last legal result).
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int N     = 8,
    parameter int DEPTH = 4
) (
    input logic              clk,
    input logic              rst,
    alu_cmd_issuer_if.master bus
);

    typedef struct packed {
`ifdef ALU_OPERAND_FWD_EN
        logic         fwd;
`endif
        logic [3:0]   op;
        logic [N-1:0] b;
        logic [N-1:0] a;
    } cmdEntry_t;

    localparam int W = $bits(cmdEntry_t);

    cmdEntry_t    pushEntry;
    cmdEntry_t    head;
    logic         push;
    logic         pop;
    logic         full;
    logic         empty;

    issuerState_e state;
    issuerState_e stateNext;
    logic         capture;
    logic         retire;
    logic         rspDone;

    logic [N-1:0] aluA;
    logic [N-1:0] aluB;
    logic [3:0]   aluSel;
    logic         errQ;
    logic [N-1:0] issueA;

    logic         rspValid;
    logic [N-1:0] rspResult;
    alu_flags_t   rspFlags;
    logic         rspErr;
    alu_flags_t   aluFlags;

    assign bus.cmd_ready = !full && !rst;
    assign push          = bus.cmd_valid && bus.cmd_ready;

    always_comb begin
        pushEntry   = '0;
        pushEntry.a = bus.cmd_a;
        pushEntry.b = bus.cmd_b;
        pushEntry.op = bus.cmd_op;
`ifdef ALU_OPERAND_FWD_EN
        pushEntry.fwd = bus.cmd_fwd;
`endif
    end

    cmd_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pushData (pushEntry),
        .pop      (pop),
        .popData  (head),
        .full     (full),
        .empty    (empty)
    );

    assign rspDone = rspValid && bus.rsp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        unique case (1'b1)
            state == IDLE:  if (!empty) stateNext = ISSUE;
            state == ISSUE: stateNext = RESP;
            state == RESP:  if (rspDone) stateNext = empty ? IDLE : ISSUE;
            default:        stateNext = IDLE;
        endcase
    end

    // A completed handshake in RESP can launch the next queued op on the same edge.
    always_comb begin
        pop     = 1'b0;
        capture = 1'b0;
        retire  = 1'b0;
        unique case (1'b1)
            state == IDLE:  pop = !empty;
            state == ISSUE: capture = 1'b1;
            state == RESP: begin
                retire = rspDone;
                pop    = rspDone && !empty;
            end
            default: ;
        endcase
    end

`ifdef ALU_OPERAND_FWD_EN
    logic [N-1:0] lastResult;

    assign issueA = head.fwd ? lastResult : head.a;

    always_ff @(posedge clk) begin
        if (rst) begin
            lastResult <= '0;
        end else if (capture && !errQ) begin
            lastResult <= bus.alu_result;
        end
    end
`else
    assign issueA = head.a;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            aluA   <= '0;
            aluB   <= '0;
            aluSel <= '0;
            errQ   <= 1'b0;
        end else if (pop) begin
            aluA   <= issueA;
            aluB   <= head.b;
            aluSel <= head.op;
            errQ   <= isIllegalOp(head.op);
        end
    end

    assign aluFlags = '{
        neg:  bus.alu_neg,
        zero: bus.alu_zero,
        cout: bus.alu_cout,
        ovf:  bus.alu_ovf
    };

    always_ff @(posedge clk) begin
        if (rst) begin
            rspValid  <= 1'b0;
            rspResult <= '0;
            rspFlags  <= '0;
            rspErr    <= 1'b0;
        end else if (capture) begin
            rspValid  <= 1'b1;
            rspResult <= errQ ? '0 : bus.alu_result;
            rspFlags  <= errQ ? FLAGS_ILLEGAL : aluFlags;
            rspErr    <= errQ;
        end else if (retire) begin
            rspValid  <= 1'b0;
        end
    end

    assign bus.alu_a      = aluA;
    assign bus.alu_b      = aluB;
    assign bus.alu_sel    = aluSel;
    assign bus.rsp_valid  = rspValid;
    assign bus.rsp_result = rspResult;
    assign bus.rsp_flags  = rspFlags;
    assign bus.rsp_err    = rspErr;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: behavioural ALU plus an in-order expected-response queue.
// Define ALU_OPERAND_FWD_EN on both RTL and bench to cover operand forwarding.
module tb_alu_cmd_issuer;
    import alu_pkg::*;

    localparam int N = 8;

    typedef struct packed {
        logic [7:0] res;
        logic [3:0] flg;
        logic       err;
    } rsp_t;

    logic clk = 1'b0;
    logic rst;
    int   passed = 0;
    int   fails = 0;
    int   total = 0;
    int   accepted = 0;
    rsp_t expQ[$];
    logic [7:0] modelLast = 8'h00;
    logic [11:0] aluOut;

    always #5 clk = ~clk;

    alu_cmd_issuer_if #(.N(N)) bus();

    alu_cmd_issuer #(.N(N), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference ALU: returns {result, neg, zero, cout, ovf}
    function automatic logic [11:0] aluRef(logic [7:0] a, logic [7:0] b, logic [3:0] op);
        logic [8:0] t;
        logic [7:0] r;
        logic c;
        logic v;
        t = 9'h000;
        c = 1'b0;
        v = 1'b0;
        case (op)
            4'd0: begin
                t = {1'b0, a} + {1'b0, b};
                r = t[7:0];
                c = t[8];
                v = (a[7] == b[7]) && (r[7] != a[7]);
            end
            4'd1: begin
                t = {1'b0, a} - {1'b0, b};
                r = t[7:0];
                c = t[8];
                v = (a[7] != b[7]) && (r[7] != a[7]);
            end
            4'd2: r = ~a;
            4'd3: r = a & b;
            4'd4: r = a | b;
            4'd5: r = a ^ b;
            4'd6: r = a >> b;
            4'd7: r = a << b;
            4'd8: r = 8'($signed(a) >>> b);
            4'd9: r = a <<< b;
            default: begin
                r = a ^ 8'h5A;
                c = 1'b1;
                v = 1'b1;
            end
        endcase
        return {r, r[7], r == 8'h00, c, v};
    endfunction

    function automatic rsp_t expectRsp(logic [7:0] a, logic [7:0] b, logic [3:0] op);
        rsp_t e;
        if (op > 4'd9) begin
            e.res = 8'h00;
            e.flg = 4'b0100;
            e.err = 1'b1;
        end else begin
            {e.res, e.flg} = aluRef(a, b, op);
            e.err = 1'b0;
        end
        return e;
    endfunction

    always_comb begin
        aluOut = aluRef(bus.alu_a, bus.alu_b, bus.alu_sel);
        bus.alu_result = aluOut[11:4];
        {bus.alu_neg, bus.alu_zero, bus.alu_cout, bus.alu_ovf} = aluOut[3:0];
    end

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: score the handshakes that the coming edge will complete.
    task automatic step();
        logic doPush;
        logic doPop;
        rsp_t e;
        logic [7:0] aEff;
        doPush = (bus.cmd_valid && bus.cmd_ready) === 1'b1;
        doPop  = (bus.rsp_valid && bus.rsp_ready) === 1'b1;
        if (doPop) begin
            check("rsp_expected", 32'(expQ.size() != 0), 32'd1);
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                check("rsp_result", 32'(bus.rsp_result), 32'(e.res));
                check("rsp_flags", 32'(bus.rsp_flags), 32'(e.flg));
                check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
            end
        end
        if (doPush) begin
            aEff = bus.cmd_a;
`ifdef ALU_OPERAND_FWD_EN
            if (bus.cmd_fwd) aEff = modelLast;
`endif
            e = expectRsp(aEff, bus.cmd_b, bus.cmd_op);
            if (!e.err) modelLast = e.res;
            expQ.push_back(e);
            accepted++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic setCmd(logic [3:0] op, logic [7:0] a, logic [7:0] b);
        bus.cmd_valid = 1'b1;
        bus.cmd_op = op;
        bus.cmd_a = a;
        bus.cmd_b = b;
    endtask

    // Returns #1 after the accept edge.
    task automatic sendOne(logic [3:0] op, logic [7:0] a, logic [7:0] b);
        int n = 0;
        setCmd(op, a, b);
        while (bus.cmd_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("send_ready", 32'(bus.cmd_ready), 32'd1);
        step();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic waitRsp(string tag);
        int n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        while ((expQ.size() != 0 || bus.rsp_valid === 1'b1) && n < 200) begin
            step();
            n++;
        end
        check("drain_empty", 32'(expQ.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        bus.rsp_ready = 1'b0;
`ifdef ALU_OPERAND_FWD_EN
        bus.cmd_fwd = 1'b0;
`endif
        setCmd(ALU_ADD, 8'h01, 8'h01);
        step();
        step();
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_alu_sel", 32'(bus.alu_sel), 32'd0);
        check("rst_alu_a", 32'(bus.alu_a), 32'd0);
        check("rst_rsp_result", 32'(bus.rsp_result), 32'd0);
        rst = 1'b0;
        bus.cmd_valid = 1'b0;
        step();
        check("ready_after_rst", 32'(bus.cmd_ready), 32'd1);

        // Latency: accept E0, ALU regs E1, response after E2.
        bus.rsp_ready = 1'b1;
        sendOne(ALU_ADD, 8'h7F, 8'h01);
        check("lat_e0_valid", 32'(bus.rsp_valid), 32'd0);
        step();
        check("lat_e1_alu_a", 32'(bus.alu_a), 32'h7F);
        check("lat_e1_alu_b", 32'(bus.alu_b), 32'h01);
        check("lat_e1_alu_sel", 32'(bus.alu_sel), 32'(ALU_ADD));
        check("lat_e1_valid", 32'(bus.rsp_valid), 32'd0);
        step();
        check("lat_e2_valid", 32'(bus.rsp_valid), 32'd1);
        check("add_result", 32'(bus.rsp_result), 32'h80);
        check("add_flags", 32'(bus.rsp_flags), 32'h9);
        drain();

        sendOne(ALU_SUB, 8'h05, 8'h05);
        waitRsp("sub");
        check("sub_result", 32'(bus.rsp_result), 32'h00);
        check("sub_zero", 32'(bus.rsp_flags[2]), 32'd1);
        check("sub_err", 32'(bus.rsp_err), 32'd0);
        drain();

        sendOne(4'hC, 8'hFF, 8'h00);
        waitRsp("illegal");
        check("ill_result", 32'(bus.rsp_result), 32'h00);
        check("ill_flags", 32'(bus.rsp_flags), 32'h4);
        check("ill_err", 32'(bus.rsp_err), 32'd1);
        drain();

        // Backpressure: one op in flight plus a full queue.
        bus.rsp_ready = 1'b0;
        accepted = 0;
        for (int i = 0; i < 12; i++) begin
            setCmd(ALU_ADD, 8'(accepted * 16 + 1), 8'(accepted));
            step();
        end
        check("bp_accepted", 32'(accepted), 32'd5);
        check("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("bp_rsp_hold", 32'(bus.rsp_result), 32'h01);
        drain();

        for (int i = 0; i < 300; i++) begin
            bus.cmd_valid = 1'($urandom_range(0, 1));
            bus.cmd_op = ($urandom_range(0, 7) == 0) ?
                4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            bus.cmd_a = 8'($urandom);
            bus.cmd_b = 8'($urandom_range(0, 9));
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
`ifdef ALU_OPERAND_FWD_EN
            bus.cmd_fwd = 1'($urandom_range(0, 1));
`endif
            step();
        end
`ifdef ALU_OPERAND_FWD_EN
        bus.cmd_fwd = 1'b0;
`endif
        drain();

`ifdef ALU_OPERAND_FWD_EN
        sendOne(ALU_ADD, 8'h03, 8'h04);
        bus.cmd_fwd = 1'b1;
        sendOne(ALU_SLL, 8'h00, 8'h01);
        bus.cmd_fwd = 1'b0;
        waitRsp("fwd_add");
        check("fwd_add_result", 32'(bus.rsp_result), 32'h07);
        step();
        waitRsp("fwd_sll");
        check("fwd_sll_result", 32'(bus.rsp_result), 32'h0E);
        drain();
`endif

        // Reset with work queued: everything in flight is dropped.
        bus.rsp_ready = 1'b0;
        sendOne(ALU_ADD, 8'h01, 8'h02);
        sendOne(ALU_SUB, 8'h09, 8'h03);
        rst = 1'b1;
        step();
        expQ.delete();
        modelLast = 8'h00;
        check("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
        check("mid_rst_ready", 32'(bus.cmd_ready), 32'd0);
        check("mid_rst_alu_a", 32'(bus.alu_a), 32'd0);
        rst = 1'b0;
        step();
        check("mid_rst_release", 32'(bus.cmd_ready), 32'd1);
        sendOne(ALU_OR, 8'hF0, 8'h0F);
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
